// File: rtl/riscv_reg_scoreboard.sv
// riscv_reg_scoreboard
// Tracks register-file writes that have been issued but not yet written back.
// It blocks issue when a source register still has a write in flight (RAW), or
// when the destination's pending counter is already full (WAW overflow). It
// also sequences a pipeline drain and counts stalled issue cycles.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   issue_*               issue-stage handshake and operand/destination info
//   wb_valid_i, wb_rd_i   writeback retiring this cycle
//   flush_i               discard every pending entry
//   drain_req_i           level request to drain; drain_done_o pulses on completion
//   busy_o, pending_o     any/per-register "write in flight" status
//   err_o                 sticky: writeback arrived for a register with nothing pending
//   stall_cnt_o           saturating count of cycles with issue_valid_i & !issue_ready_o
module riscv_reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2,
  parameter int STALL_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [ADDR_W-1:0]   issue_rs1_i,
  input  logic [ADDR_W-1:0]   issue_rs2_i,
  input  logic                issue_use_rs1_i,
  input  logic                issue_use_rs2_i,
  input  logic [ADDR_W-1:0]   issue_rd_i,
  input  logic                issue_wen_i,
  input  logic                wb_valid_i,
  input  logic [ADDR_W-1:0]   wb_rd_i,
  input  logic                flush_i,
  input  logic                drain_req_i,
  output logic                drain_done_o,
  output logic                busy_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                err_o,
  output logic [STALL_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    Run   = 2'd0,
    Drain = 2'd1,
    Done  = 2'd2
  } stateT;

  localparam logic [CNT_W-1:0] CntMax = '1;

  stateT               stateReg, stateNext;
  logic [CNT_W-1:0]    pendCnt [NUM_REGS];
  logic [NUM_REGS-1:0] pendingVec;
  logic                errReg;
  logic [STALL_W-1:0]  stallReg;

  logic rs1Haz, rs2Haz, overflow, issueReady, accept;
  logic incEn, decEn, sameReg, errSet;

  // No writeback bypass: hazards look only at the registered counters.
  assign rs1Haz = issue_use_rs1_i & (issue_rs1_i != '0) & pendingVec[issue_rs1_i];
  assign rs2Haz = issue_use_rs2_i & (issue_rs2_i != '0) & pendingVec[issue_rs2_i];
  assign overflow = issue_wen_i & (issue_rd_i != '0) & (pendCnt[issue_rd_i] == CntMax);

  // Held low while reset is asserted so every output reads zero without a clock edge.
  assign issueReady = ~rst_i & (stateReg == Run) & ~rs1Haz & ~rs2Haz & ~overflow & ~flush_i;
  assign accept     = issue_valid_i & issueReady;

  assign incEn   = accept & issue_wen_i & (issue_rd_i != '0);
  assign decEn   = wb_valid_i & (wb_rd_i != '0);
  // An increment and decrement of the same register cancel, even from zero.
  assign sameReg = incEn & decEn & (issue_rd_i == wb_rd_i);
  assign errSet  = decEn & ~flush_i & ~sameReg & (pendCnt[wb_rd_i] == '0);

  assign pendCnt[0]    = '0;
  assign pendingVec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : gReg
      logic [CNT_W-1:0] cntReg;
      logic             incHit, decHit;

      assign incHit = incEn & (issue_rd_i == ADDR_W'(gi));
      assign decHit = decEn & (wb_rd_i == ADDR_W'(gi));

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cntReg <= '0;
        end else if (flush_i) begin
          cntReg <= '0;
        end else if (incHit && !decHit) begin
          cntReg <= cntReg + 1'b1;
        end else if (decHit && !incHit && (cntReg != '0)) begin
          cntReg <= cntReg - 1'b1;
        end
      end

      assign pendCnt[gi]    = cntReg;
      assign pendingVec[gi] = |cntReg;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateReg <= Run;
      errReg   <= 1'b0;
      stallReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (errSet) begin
        errReg <= 1'b1;
      end
      if (issue_valid_i && !issueReady && (stallReg != '1)) begin
        stallReg <= stallReg + 1'b1;
      end
    end
  end

  // Drain completion is judged on the registered counters, not the post-update value.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      Run:     if (drain_req_i) stateNext = Drain;
      Drain:   if (!(|pendingVec)) stateNext = Done;
      Done:    stateNext = Run;
      default: stateNext = Run;
    endcase
  end

  assign issue_ready_o = issueReady;
  assign drain_done_o  = (stateReg == Done);
  assign busy_o        = |pendingVec;
  assign pending_o     = pendingVec;
  assign err_o         = errReg;
  assign stall_cnt_o   = stallReg;

endmodule

// File: tb/tb_riscv_reg_scoreboard.sv
// tb_riscv_reg_scoreboard
// Directed scenarios followed by randomized traffic, all compared each cycle
// against a behavioural model that keeps an integer count of in-flight writes
// per register.
module tb_riscv_reg_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_MAX  = 3;
  localparam int STALL_MAX = 65535;

  logic              clk_i;
  logic              rst_i;
  logic              issue_valid_i;
  logic              issue_ready_o;
  logic [ADDR_W-1:0] issue_rs1_i;
  logic [ADDR_W-1:0] issue_rs2_i;
  logic              issue_use_rs1_i;
  logic              issue_use_rs2_i;
  logic [ADDR_W-1:0] issue_rd_i;
  logic              issue_wen_i;
  logic              wb_valid_i;
  logic [ADDR_W-1:0] wb_rd_i;
  logic              flush_i;
  logic              drain_req_i;
  logic              drain_done_o;
  logic              busy_o;
  logic [31:0]       pending_o;
  logic              err_o;
  logic [15:0]       stall_cnt_o;

  riscv_reg_scoreboard dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_rs1_i    (issue_rs1_i),
    .issue_rs2_i    (issue_rs2_i),
    .issue_use_rs1_i(issue_use_rs1_i),
    .issue_use_rs2_i(issue_use_rs2_i),
    .issue_rd_i     (issue_rd_i),
    .issue_wen_i    (issue_wen_i),
    .wb_valid_i     (wb_valid_i),
    .wb_rd_i        (wb_rd_i),
    .flush_i        (flush_i),
    .drain_req_i    (drain_req_i),
    .drain_done_o   (drain_done_o),
    .busy_o         (busy_o),
    .pending_o      (pending_o),
    .err_o          (err_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int failures = 0;

  // Reference model: pending writes per register, sticky error, stall count,
  // and drain phase (0 = running, 1 = draining, 2 = drain just completed).
  int mPend [NUM_REGS];
  bit mErr;
  int mStall;
  int mPhase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int r = 0; r < NUM_REGS; r++) mPend[r] = 0;
    mErr = 0;
    mStall = 0;
    mPhase = 0;
  endfunction

  function automatic bit modelBusy();
    for (int r = 1; r < NUM_REGS; r++) if (mPend[r] != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] modelPending();
    logic [31:0] v = '0;
    for (int r = 1; r < NUM_REGS; r++) v[r] = (mPend[r] != 0);
    return v;
  endfunction

  function automatic bit modelReady();
    bit haz, ovf;
    int rs1 = int'(issue_rs1_i);
    int rs2 = int'(issue_rs2_i);
    int rd  = int'(issue_rd_i);
    haz = (issue_use_rs1_i && rs1 != 0 && mPend[rs1] != 0) ||
          (issue_use_rs2_i && rs2 != 0 && mPend[rs2] != 0);
    ovf = issue_wen_i && rd != 0 && mPend[rd] == CNT_MAX;
    return !rst_i && mPhase == 0 && !haz && !ovf && !flush_i;
  endfunction

  function automatic void idle();
    issue_valid_i = 0; issue_use_rs1_i = 0; issue_use_rs2_i = 0;
    issue_rs1_i = 0; issue_rs2_i = 0; issue_rd_i = 0; issue_wen_i = 0;
    wb_valid_i = 0; wb_rd_i = 0; flush_i = 0; drain_req_i = 0;
  endfunction

  // Called just after a falling edge with inputs set; compares all outputs
  // against the model, advances the model past the next rising edge, and
  // returns at the following falling edge.
  task automatic step();
    bit rdy, acc, inc, dec, busyNow;
    int rd, wr;
    #1;
    rdy = modelReady();
    busyNow = modelBusy();
    check("ready", issue_ready_o, rdy);
    check("busy", busy_o, busyNow);
    check("pending", pending_o, modelPending());
    check("err", err_o, mErr);
    check("stall", stall_cnt_o, mStall);
    check("done", drain_done_o, mPhase == 2);

    acc = issue_valid_i && rdy;
    rd  = int'(issue_rd_i);
    wr  = int'(wb_rd_i);
    if (flush_i) begin
      for (int r = 0; r < NUM_REGS; r++) mPend[r] = 0;
    end else begin
      inc = acc && issue_wen_i && rd != 0;
      dec = wb_valid_i && wr != 0;
      if (!(inc && dec && rd == wr)) begin
        if (dec) begin
          if (mPend[wr] == 0) mErr = 1;
          else mPend[wr]--;
        end
        if (inc) mPend[rd]++;
      end
    end
    if (issue_valid_i && !rdy && mStall < STALL_MAX) mStall++;
    case (mPhase)
      0: if (drain_req_i) mPhase = 1;
      1: if (!busyNow) mPhase = 2;
      default: mPhase = 0;
    endcase
    @(negedge clk_i);
  endtask

  // Asserts reset between clock edges and checks that outputs clear immediately.
  task automatic resetDut();
    rst_i = 1;
    #1;
    check("rst_ready", issue_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_pending", pending_o, 0);
    check("rst_err", err_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    check("rst_done", drain_done_o, 0);
    modelReset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
  endtask

  task automatic issueWrite(input int rd);
    idle();
    issue_valid_i = 1; issue_wen_i = 1; issue_rd_i = ADDR_W'(rd);
    step();
  endtask

  task automatic writeBack(input int rd);
    idle();
    wb_valid_i = 1; wb_rd_i = ADDR_W'(rd);
    step();
  endtask

  initial begin
    idle();
    modelReset();
    rst_i = 1;
    @(negedge clk_i);
    resetDut();

    // RAW hazard on x5 and its release one cycle after writeback.
    issueWrite(5);
    check("t1_pend5", pending_o, 32'h0000_0020);
    idle();
    issue_valid_i = 1; issue_use_rs1_i = 1; issue_rs1_i = 5;
    step();
    check("t1_stall", stall_cnt_o, 1);
    wb_valid_i = 1; wb_rd_i = 5;
    step();
    wb_valid_i = 0;
    step();
    idle();
    step();

    // WAW overflow on x7.
    issueWrite(7);
    issueWrite(7);
    issueWrite(7);
    idle();
    issue_valid_i = 1; issue_wen_i = 1; issue_rd_i = 7;
    #1 check("t2_ovf_ready", issue_ready_o, 0);
    step();
    wb_valid_i = 1; wb_rd_i = 7;
    step();
    wb_valid_i = 0;
    step();
    writeBack(7);
    writeBack(7);
    writeBack(7);

    // Same-cycle issue and writeback of x3, then underflow on x9.
    issueWrite(3);
    idle();
    issue_valid_i = 1; issue_wen_i = 1; issue_rd_i = 3;
    wb_valid_i = 1; wb_rd_i = 3;
    step();
    check("t3_pend3", pending_o, 32'h0000_0008);
    check("t3_err0", err_o, 0);
    writeBack(9);
    check("t3_err1", err_o, 1);
    idle();
    step();
    check("t3_err_sticky", err_o, 1);

    // Flush with a concurrent issue.
    issueWrite(2);
    issueWrite(4);
    issueWrite(4);
    idle();
    issue_valid_i = 1; issue_wen_i = 1; issue_rd_i = 6; flush_i = 1;
    #1 check("t4_flush_ready", issue_ready_o, 0);
    step();
    check("t4_pending", pending_o, 0);
    check("t4_busy", busy_o, 0);

    // Drain sequence waiting on x8.
    issueWrite(8);
    idle();
    drain_req_i = 1;
    step();
    idle();
    step();
    check("t5_drain_ready", issue_ready_o, 0);
    writeBack(8);
    idle();
    step();
    check("t5_done", drain_done_o, 1);
    check("t5_done_ready", issue_ready_o, 0);
    step();
    check("t5_done_pulse", drain_done_o, 0);
    check("t5_run_ready", issue_ready_o, 1);

    // Long hazard stall saturates the stall counter.
    issueWrite(5);
    idle();
    issue_valid_i = 1; issue_use_rs2_i = 1; issue_rs2_i = 5;
    for (int i = 0; i < 70000; i++) step();
    check("t6_stall_sat", stall_cnt_o, 16'hFFFF);
    writeBack(5);

    // Asynchronous reset in the middle of a drain.
    issueWrite(10);
    idle();
    drain_req_i = 1;
    step();
    idle();
    step();
    resetDut();

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      issue_valid_i   = ($urandom_range(0, 3) != 0);
      issue_use_rs1_i = $urandom_range(0, 1);
      issue_use_rs2_i = $urandom_range(0, 1);
      issue_rs1_i     = ADDR_W'($urandom_range(0, 7));
      issue_rs2_i     = ADDR_W'($urandom_range(0, 7));
      issue_rd_i      = ADDR_W'($urandom_range(0, 7));
      issue_wen_i     = ($urandom_range(0, 3) != 0);
      wb_valid_i      = ($urandom_range(0, 9) < 4);
      wb_rd_i         = ADDR_W'($urandom_range(0, 7));
      flush_i         = ($urandom_range(0, 99) < 3);
      drain_req_i     = ($urandom_range(0, 99) < 5);
      step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
